// File: rtl/systolic_out_writer_if.sv
// rtl/systolic_out_writer_if.sv - tile handshake and output SRAM write bus
//
// Purpose: bundles the tile input handshake (sizes, bases, accumulator tile)
// and the output SRAM write port of systolic_out_writer.
// Modports:
//   master - tile producer / SRAM observer (drives tile, samples SRAM writes)
//   slave  - systolic_out_writer side (accepts tile, drives SRAM writes)
interface systolic_out_writer_if #(
  parameter int ACC_BWIDTH        = 32,
  parameter int PE_ARRAY_NUM_ROWS = 4,
  parameter int PE_ARRAY_NUM_COLS = 4,
  parameter int OUT_SRAM_AWIDTH   = 10,
  parameter int OUT_SRAM_BWIDTH   = 4*32,
  parameter int MAX_M_SIZE_LOG2   = 9,
  parameter int MAX_N_SIZE_LOG2   = 9
);
  logic [MAX_M_SIZE_LOG2-1:0]                                  M_SIZE_in;
  logic [MAX_N_SIZE_LOG2-1:0]                                  N_SIZE_in;
  logic                                                        TILE_VALID_in;
  logic                                                        TILE_READY_out;
  logic [MAX_M_SIZE_LOG2-1:0]                                  TILE_ROW_BASE_in;
  logic [MAX_N_SIZE_LOG2-1:0]                                  TILE_COL_BASE_in;
  logic [PE_ARRAY_NUM_ROWS*PE_ARRAY_NUM_COLS*ACC_BWIDTH-1:0]   TILE_ACC_in;
  logic                                                        OUT_SRAM_WEN_out;
  logic [OUT_SRAM_AWIDTH-1:0]                                  OUT_SRAM_ADDR_out;
  logic [OUT_SRAM_BWIDTH-1:0]                                  OUT_SRAM_WDATA_out;
  logic                                                        TILE_DONE_out;

  modport master (
    output M_SIZE_in, N_SIZE_in, TILE_VALID_in, TILE_ROW_BASE_in,
           TILE_COL_BASE_in, TILE_ACC_in,
    input  TILE_READY_out, OUT_SRAM_WEN_out, OUT_SRAM_ADDR_out,
           OUT_SRAM_WDATA_out, TILE_DONE_out
  );

  modport slave (
    input  M_SIZE_in, N_SIZE_in, TILE_VALID_in, TILE_ROW_BASE_in,
           TILE_COL_BASE_in, TILE_ACC_in,
    output TILE_READY_out, OUT_SRAM_WEN_out, OUT_SRAM_ADDR_out,
           OUT_SRAM_WDATA_out, TILE_DONE_out
  );
endinterface

// File: rtl/systolic_out_writer.sv
// rtl/systolic_out_writer.sv - systolic tile write-back into output SRAM
//
// Purpose: accepts one R x C accumulator tile, writes it row by row into the
// row-major output SRAM (one word per tile row), suppressing rows beyond M and
// zeroing lanes beyond N, then pulses TILE_DONE_out for one cycle.
// Ports:
//   CLK   - clock, rising edge
//   RSTn  - asynchronous active-low reset
//   STALL - freezes all state; write strobe and done pulse forced low
//   bus   - tile handshake + SRAM write port (systolic_out_writer_if.slave)
module systolic_out_writer #(
  parameter int ACC_BWIDTH             = 32,
  parameter int PE_ARRAY_NUM_ROWS      = 4,
  parameter int PE_ARRAY_NUM_COLS      = 4,
  parameter int PE_ARRAY_NUM_COLS_LOG2 = 2,
  parameter int OUT_SRAM_AWIDTH        = 10,
  parameter int OUT_SRAM_BWIDTH        = 4*32,
  parameter int MAX_M_SIZE_LOG2        = 9,
  parameter int MAX_N_SIZE_LOG2        = 9
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 STALL,
  systolic_out_writer_if.slave bus
);
  localparam int R     = PE_ARRAY_NUM_ROWS;
  localparam int C     = PE_ARRAY_NUM_COLS;
  localparam int MW    = MAX_M_SIZE_LOG2;
  localparam int NWD   = MAX_N_SIZE_LOG2;
  localparam int AW    = OUT_SRAM_AWIDTH;
  localparam int PW    = MW + NWD;
  localparam int ROW_W = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t                     r_state, w_state_next;
  logic [ROW_W-1:0]           r_row, w_row_next;
  logic [R*C*ACC_BWIDTH-1:0]  r_acc;
  logic [MW-1:0]              r_row_base, r_m;
  logic [NWD-1:0]             r_col_base, r_n, r_nw;
  logic                       r_wen, r_done;
  logic [AW-1:0]              r_addr;
  logic [OUT_SRAM_BWIDTH-1:0] r_wdata;

  logic                       w_ready, w_accept;
  logic [NWD:0]               w_n_round;
  logic [NWD-1:0]             w_nw_in;
  logic [MW:0]                w_row_abs;
  logic                       w_row_in_range;
  logic [PW-1:0]              w_prod;
  logic [AW-1:0]              w_addr_calc;
  logic [OUT_SRAM_BWIDTH-1:0] w_wdata_calc;
  logic                       w_wen_next, w_done_next;
  logic [AW-1:0]              w_addr_next;
  logic [OUT_SRAM_BWIDTH-1:0] w_wdata_next;

  assign w_ready  = (r_state == S_IDLE) && !STALL;
  assign w_accept = bus.TILE_VALID_in && w_ready;

  // Words per output row: N rounded up to a whole number of C-lane words.
  assign w_n_round = {1'b0, bus.N_SIZE_in} + (NWD+1)'(C - 1);
  assign w_nw_in   = NWD'(w_n_round >> PE_ARRAY_NUM_COLS_LOG2);

  // Absolute output row kept one bit wider so the M comparison cannot wrap.
  assign w_row_abs      = {1'b0, r_row_base} + (MW+1)'(r_row);
  assign w_row_in_range = w_row_abs < {1'b0, r_m};
  assign w_prod         = PW'(w_row_abs[MW-1:0]) * PW'(r_nw);
  assign w_addr_calc    = AW'(w_prod + PW'(r_col_base >> PE_ARRAY_NUM_COLS_LOG2));

  always_comb begin
    w_wdata_calc = '0;
    for (int c = 0; c < C; c++) begin
      if (({1'b0, r_col_base} + (NWD+1)'(c)) < {1'b0, r_n})
        w_wdata_calc[c*ACC_BWIDTH +: ACC_BWIDTH] =
          r_acc[(int'(r_row)*C + c)*ACC_BWIDTH +: ACC_BWIDTH];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_wen_next   = 1'b0;
    w_done_next  = 1'b0;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    if (!STALL) begin
      case (r_state)
        S_IDLE: begin
          if (bus.TILE_VALID_in) begin
            w_state_next = S_WRITE;
            w_row_next   = '0;
          end
        end
        S_WRITE: begin
          // Out-of-range rows still advance the walk, just without a strobe.
          w_wen_next   = w_row_in_range;
          w_addr_next  = w_addr_calc;
          w_wdata_next = w_wdata_calc;
          w_row_next   = r_row + ROW_W'(1);
          if (r_row == ROW_W'(R - 1))
            w_state_next = S_DONE;
        end
        S_DONE: begin
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_acc      <= '0;
      r_row_base <= '0;
      r_col_base <= '0;
      r_m        <= '0;
      r_n        <= '0;
      r_nw       <= '0;
      r_wen      <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
      r_wen   <= w_wen_next;
      r_done  <= w_done_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      if (w_accept) begin
        r_acc      <= bus.TILE_ACC_in;
        r_row_base <= bus.TILE_ROW_BASE_in;
        r_col_base <= bus.TILE_COL_BASE_in;
        r_m        <= bus.M_SIZE_in;
        r_n        <= bus.N_SIZE_in;
        r_nw       <= w_nw_in;
      end
    end
  end

  assign bus.TILE_READY_out     = w_ready;
  assign bus.OUT_SRAM_WEN_out   = r_wen;
  assign bus.OUT_SRAM_ADDR_out  = r_addr;
  assign bus.OUT_SRAM_WDATA_out = r_wdata;
  assign bus.TILE_DONE_out      = r_done;
endmodule

// File: tb/tb_systolic_out_writer.sv
// tb/tb_systolic_out_writer.sv - self-checking bench for systolic_out_writer
module tb_systolic_out_writer;
  localparam int R   = 4;
  localparam int C   = 4;
  localparam int ACC = 32;

  logic CLK = 1'b0;
  logic RSTn = 1'b1;
  logic STALL = 1'b0;

  systolic_out_writer_if #(
    .ACC_BWIDTH(ACC), .PE_ARRAY_NUM_ROWS(R), .PE_ARRAY_NUM_COLS(C),
    .OUT_SRAM_AWIDTH(10), .OUT_SRAM_BWIDTH(C*ACC),
    .MAX_M_SIZE_LOG2(9), .MAX_N_SIZE_LOG2(9)
  ) bus ();

  systolic_out_writer #(
    .ACC_BWIDTH(ACC), .PE_ARRAY_NUM_ROWS(R), .PE_ARRAY_NUM_COLS(C),
    .PE_ARRAY_NUM_COLS_LOG2(2), .OUT_SRAM_AWIDTH(10), .OUT_SRAM_BWIDTH(C*ACC),
    .MAX_M_SIZE_LOG2(9), .MAX_N_SIZE_LOG2(9)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .STALL(STALL), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Tile currently presented on the inputs.
  int          d_rb, d_cb, d_m, d_n;
  int unsigned d_acc [R][C];

  // Reference model: tile in flight and count of non-stalled edges since accept.
  bit          m_busy = 1'b0;
  int          m_k;
  int          m_rb, m_cb, m_m, m_n;
  int unsigned m_acc [R][C];
  logic        exp_wen, exp_done;
  logic [9:0]  exp_addr;
  logic [127:0] exp_wdata;

  int           wlog[$];
  logic [127:0] dlog[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_tile(input int rb, input int cb, input int m, input int n, input bit seq);
    d_rb = rb; d_cb = cb; d_m = m; d_n = n;
    bus.TILE_ROW_BASE_in = 9'(rb);
    bus.TILE_COL_BASE_in = 9'(cb);
    bus.M_SIZE_in        = 9'(m);
    bus.N_SIZE_in        = 9'(n);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        d_acc[r][c] = seq ? 32'(4*r + c + 1) : $urandom;
        bus.TILE_ACC_in[(r*C+c)*ACC +: ACC] = d_acc[r][c];
      end
  endtask

  // Events of a tile sit at fixed non-stalled-edge offsets from its accept:
  // rows at offsets 1..R, done at R+1; stalled edges produce nothing.
  task automatic model_edge(input bit valid, input bit stall);
    int row, ra, nw;
    exp_wen  = 1'b0;
    exp_done = 1'b0;
    if (stall) return;
    if (m_busy) begin
      m_k++;
      if (m_k <= R) begin
        row = m_k - 1;
        ra  = m_rb + row;
        nw  = (m_n + C - 1) / C;
        if (ra < m_m) begin
          exp_wen   = 1'b1;
          exp_addr  = 10'((ra * nw + m_cb / C) % 1024);
          exp_wdata = '0;
          for (int c = 0; c < C; c++)
            if (m_cb + c < m_n) exp_wdata[c*ACC +: ACC] = m_acc[row][c];
        end
      end else begin
        exp_done = 1'b1;
        m_busy   = 1'b0;
      end
    end else if (valid) begin
      m_busy = 1'b1;
      m_k = 0;
      m_rb = d_rb; m_cb = d_cb; m_m = d_m; m_n = d_n;
      m_acc = d_acc;
    end
  endtask

  // Called at a falling edge; drives, steps one rising edge, checks at the next falling edge.
  task automatic cyc(input bit valid, input bit stall);
    bus.TILE_VALID_in = valid;
    STALL = stall;
    #1;
    chk("ready", bus.TILE_READY_out, !m_busy && !stall);
    @(posedge CLK);
    model_edge(valid, stall);
    @(negedge CLK);
    chk("wen", bus.OUT_SRAM_WEN_out, exp_wen);
    chk("done", bus.TILE_DONE_out, exp_done);
    if (exp_wen) begin
      chk("addr", bus.OUT_SRAM_ADDR_out, exp_addr);
      chk("wdata", bus.OUT_SRAM_WDATA_out, exp_wdata);
    end
    if (bus.OUT_SRAM_WEN_out === 1'b1) begin
      wlog.push_back(int'(bus.OUT_SRAM_ADDR_out));
      dlog.push_back(bus.OUT_SRAM_WDATA_out);
    end
  endtask

  task automatic run_tile();
    wlog.delete();
    dlog.delete();
    cyc(1'b1, 1'b0);
    repeat (R + 1) cyc(1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wen"}, bus.OUT_SRAM_WEN_out, 1'b0);
    chk({tag, "_done"}, bus.TILE_DONE_out, 1'b0);
    chk({tag, "_addr"}, bus.OUT_SRAM_ADDR_out, 10'd0);
    chk({tag, "_wdata"}, bus.OUT_SRAM_WDATA_out, 128'd0);
    chk({tag, "_ready"}, bus.TILE_READY_out, 1'b1);
  endtask

  initial begin
    bus.TILE_VALID_in = 1'b0;
    load_tile(0, 0, 0, 0, 1'b1);
    #2 RSTn = 1'b0;
    #1 chk_reset_outputs("rst");
    @(negedge CLK);
    RSTn = 1'b1;

    // Single tile at the origin.
    load_tile(0, 0, 4, 4, 1'b1);
    run_tile();
    chk("single_nwr", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++) chk("single_addr", wlog[i], i);
    if (dlog.size() > 0)
      chk("single_row0", dlog[0], 128'h00000004_00000003_00000002_00000001);

    // Address arithmetic with non-zero bases.
    load_tile(8, 12, 16, 16, 1'b0);
    run_tile();
    chk("amath_nwr", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++) chk("amath_addr", wlog[i], 35 + 4*i);

    // Partial tile: two rows, two lanes.
    load_tile(4, 4, 6, 6, 1'b0);
    run_tile();
    chk("part_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("part_addr0", wlog[0], 9);
      chk("part_addr1", wlog[1], 11);
      chk("part_lane23", dlog[0][127:64], 64'd0);
    end

    // Two stalled edges after the second write.
    load_tile(0, 0, 4, 4, 1'b1);
    wlog.delete();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    chk("stall_nwr", wlog.size(), 4);
    for (int i = 0; i < wlog.size() && i < 4; i++) chk("stall_addr", wlog[i], i);

    // Reset in the middle of a tile.
    load_tile(0, 0, 4, 4, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    #2 RSTn = 1'b0;
    #1 chk_reset_outputs("midrst");
    m_busy = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    wlog.delete();
    repeat (R + 2) cyc(1'b0, 1'b0);
    chk("midrst_nwr", wlog.size(), 0);

    // VALID held high: second accept lands exactly R+2 edges after the first.
    load_tile(0, 0, 4, 4, 1'b1);
    wlog.delete();
    repeat (2 * (R + 2)) cyc(1'b1, 1'b0);
    chk("bp_nwr", wlog.size(), 8);
    cyc(1'b0, 1'b0);

    // Empty tile: M = 0.
    load_tile(0, 0, 0, 4, 1'b0);
    run_tile();
    chk("empty_nwr", wlog.size(), 0);

    // Randomized traffic with random stalls and sizes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0)
        load_tile(4 * $urandom_range(0, 11), 4 * $urandom_range(0, 11),
                  $urandom_range(0, 48), $urandom_range(0, 48), 1'b0);
      else
        load_tile(4 * $urandom_range(0, 127), 4 * $urandom_range(0, 127),
                  $urandom_range(0, 511), $urandom_range(0, 511), 1'b0);
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
    end
    repeat (R + 2) cyc(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_out_writer.md
# systolic_out_writer

Output write-back stage directly downstream of the systolic PE array. It accepts one completed tile of PE_ARRAY_NUM_ROWS x PE_ARRAY_NUM_COLS accumulator results through a valid/ready handshake. It writes the tile row by row into the output SRAM, one SRAM word per tile row, using the row-major output-matrix layout. Rows and columns that fall outside M_SIZE/N_SIZE are suppressed or zeroed, and a one-cycle done pulse is raised once the tile has been fully written.

## Interface
- ACC_BWIDTH, 32, width of one accumulator element
- PE_ARRAY_NUM_ROWS, 4, tile rows (R)
- PE_ARRAY_NUM_COLS, 4, tile columns / SRAM lanes (C)
- PE_ARRAY_NUM_COLS_LOG2, 2, log2(C)
- OUT_SRAM_AWIDTH, 10, output SRAM address width
- OUT_SRAM_BWIDTH, 4*32, output word width, equal to C*ACC_BWIDTH
- MAX_M_SIZE_LOG2, 9, width of M size and row indices
- MAX_N_SIZE_LOG2, 9, width of N size and column indices

Ports:
- CLK  in  1  sole clock, rising edge
- RSTn  in  1  asynchronous, active-low reset
- STALL  in  1  freezes all state while high
- M_SIZE_in  in  MAX_M_SIZE_LOG2  output rows; sampled at tile accept
- N_SIZE_in  in  MAX_N_SIZE_LOG2  output columns; sampled at tile accept
- TILE_VALID_in  in  1  tile results valid
- TILE_READY_out  out  1  block can accept a tile
- TILE_ROW_BASE_in  in  MAX_M_SIZE_LOG2  first output row of tile, a multiple of R
- TILE_COL_BASE_in  in  MAX_N_SIZE_LOG2  first output column of tile, a multiple of C
- TILE_ACC_in  in  R*C*ACC_BWIDTH  element (r,c) at bits [(r*C+c)*ACC_BWIDTH +: ACC_BWIDTH]
- OUT_SRAM_WEN_out  out  1  write strobe
- OUT_SRAM_ADDR_out  out  OUT_SRAM_AWIDTH  write address
- OUT_SRAM_WDATA_out  out  OUT_SRAM_BWIDTH  lane c at bits [c*ACC_BWIDTH +: ACC_BWIDTH]
- TILE_DONE_out  out  1  one-cycle pulse when tile write-back completes

## Operation
- FSM states: IDLE, WRITE, DONE.
- TILE_READY_out = (state==IDLE) && !STALL. It is combinational from registered state.
- **Accept:** occurs on an edge with VALID && READY. On accept, the block:
  - captures TILE_ACC_in, both bases, M_SIZE_in and N_SIZE_in;
  - computes NW = (N + C-1) >> PE_ARRAY_NUM_COLS_LOG2, the words per output row;
  - clears row counter r to 0 and moves to WRITE.
- **WRITE, each non-stalled edge:**
  - Registers the output word for row r:
    - ADDR = ((row_base + r) * NW + (col_base >> COLS_LOG2)), truncated to the low OUT_SRAM_AWIDTH bits. The product is computed at MAX_M_SIZE_LOG2+MAX_N_SIZE_LOG2 bits before truncation.
    - WDATA lane c = acc[r][c] if col_base+c < N, else 0.
    - WEN = 1 only if row_base + r < M. Otherwise WEN = 0, and ADDR/WDATA may take any value.
  - Increments r. After r = R-1 the state moves to DONE.
- **DONE, next non-stalled edge:** WEN registers 0, TILE_DONE_out registers 1, and the state moves to IDLE.
- **All other non-stalled edges:** WEN and TILE_DONE_out register 0. ADDR and WDATA hold.
- **STALL = 1:**
  - state, r and captured data hold;
  - WEN and TILE_DONE_out register 0, so no duplicate writes occur;
  - ADDR and WDATA hold;
  - no tile is accepted.
- **M=0 or N=0:** the tile is still accepted and walked through all R rows with no WEN, and TILE_DONE_out still pulses.

## Timing
- **Reset:** when RSTn goes low, all registered outputs (WEN, ADDR, WDATA, TILE_DONE_out) go to 0 immediately, independent of CLK. The state goes to IDLE, so TILE_READY_out = 1 whenever STALL = 0.
- **Reset mid-tile:** the in-flight tile is dropped. No further writes and no DONE pulse are produced for it.
- **Latency, accept edge T0 with no stall:**
  - row r write visible after edge T(r+1), for r = 0..R-1;
  - TILE_DONE_out high for the cycle after edge T(R+1);
  - TILE_READY_out high from that same cycle, so the next accept is at edge T(R+2) at the earliest.
- **Throughput:** one tile per R+2 cycles.
- Each stalled edge delays every subsequent event by exactly one cycle.
- Inputs are ignored while READY = 0. VALID may stay high; the tile is taken on the first edge with READY = 1.

## Test plan
- **Single tile:** M=N=4, bases 0,0, acc[r][c]=4r+c+1, accept at T0 -> WEN=1 after T1..T4 with ADDR 0,1,2,3. Row 0 WDATA lanes = 1,2,3,4. TILE_DONE_out=1 for exactly one cycle after T5.
- **Address math:** M=N=16, row_base=8, col_base=12 -> ADDR 35, 39, 43, 47; all four lanes carry data.
- **Partial tile:** M=N=6, row_base=4, col_base=4 (NW=2) -> two writes only, ADDR 9 and 11. Lanes 2,3 are 0. No WEN for rows 6,7. DONE still pulses after T5.
- **Stall:** STALL=1 for 2 cycles right after the second write -> WEN=0 during the stall, no address repeated, rows 2,3 written afterwards, DONE after T7.
- **Reset mid-tile:** RSTn=0 after the second write -> all outputs 0 asynchronously. After release, READY=1 and no further WEN occurs until a new tile is accepted.
- **Busy/backpressure and empty:** VALID held high during write-back -> second tile accepted exactly at T(R+2). A tile with M=0 -> zero WEN cycles, DONE pulse at the normal time.
